counter_tx: RTL and testbench
=============================

COUNTER_TX -- requirements
Module: counter_tx

Interface
REQ-001 Parameter CNT_WIDTH, default 4: width of the count register and of cnt_o; legal range 1..32.
REQ-002 Parameter CNT_MAX, default 9: terminal count value; legal range 1..2**CNT_WIDTH-1; CNT_MAX=0 is illegal.
REQ-003 Parameter TX_WIDTH, default 8: width of the transaction counter tx_cnt_o; legal range 1..32.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flag_cnt_i  input  1  count enable; count advances only while high.
REQ-007 cnt_o  output  CNT_WIDTH  current count value, registered.
REQ-008 end_cnt_o  output  1  terminal-count strobe, combinational.
REQ-009 tx_valid_o  output  1  one-cycle transmit strobe, registered.
REQ-010 tx_cnt_o  output  TX_WIDTH  number of transmit strobes issued, registered, modulo 2**TX_WIDTH.

Function
REQ-011 end_cnt_o SHALL equal flag_cnt_i AND (cnt_o == CNT_MAX).
- No other term in the expression.
- No combinational path from rst to end_cnt_o.
REQ-012 On a clock edge with rst low, flag_cnt_i high and end_cnt_o low, cnt_o SHALL increment by 1.
REQ-013 On a clock edge with rst low and end_cnt_o high, cnt_o SHALL wrap to 0.
- One full period is therefore CNT_MAX+1 enabled cycles.
REQ-014 On a clock edge with rst low and flag_cnt_i low, cnt_o SHALL hold its value.
- Counting resumes from the held value when flag_cnt_i returns high.
REQ-015 If cnt_o is greater than CNT_MAX, on a clock edge with rst low and flag_cnt_i high, cnt_o SHALL load 0.
- Out-of-range recovery; this state is unreachable in normal operation.
REQ-016 end_cnt_o SHALL be high for exactly one cycle per wrap and low in the following cycle.
- Guaranteed by CNT_MAX >= 1.
- Successive rising edges of end_cnt_o are CNT_MAX+1 enabled cycles apart.
REQ-017 tx_valid_o SHALL be high in the cycle immediately after any cycle in which end_cnt_o was high at the clock edge, and low otherwise.
- Latency is 1 cycle.
REQ-018 tx_cnt_o SHALL increment by 1, wrapping from all-ones to 0, on every clock edge at which end_cnt_o is high and rst is low.
- The new value appears in the same cycle that tx_valid_o is high.
REQ-019 flag_cnt_i deasserted while cnt_o == CNT_MAX SHALL suppress end_cnt_o and hold cnt_o.
- No tx_valid_o or tx_cnt_o update occurs until the enable returns.
REQ-020 All outputs other than end_cnt_o SHALL change only on rising clk edges.

Reset
REQ-021 On a clock edge with rst high, cnt_o SHALL load 0, tx_valid_o 0 and tx_cnt_o 0, regardless of flag_cnt_i.
REQ-022 While rst is high, end_cnt_o SHALL be low unless flag_cnt_i is high and cnt_o == CNT_MAX.
- After the first reset edge cnt_o is 0, so end_cnt_o is low.
REQ-023 Reset asserted mid-count or coincident with end_cnt_o SHALL take priority over every other update.
- No tx_valid_o pulse follows that edge.
REQ-024 Output values before the first reset edge are undefined; the environment SHALL apply rst for at least 1 clock edge.

Verification
REQ-025 Defaults, rst high for 2 edges then flag_cnt_i=1 -> cnt_o goes 0,1,...,9,0.
- end_cnt_o is high only while cnt_o=9.
- tx_valid_o is high the next cycle, when cnt_o=0.
- tx_cnt_o=1 after the first wrap.
REQ-026 Continuous enable for 25 cycles -> end_cnt_o rising edges exactly 10 cycles apart; tx_cnt_o=2 after the second wrap.
REQ-027 flag_cnt_i dropped for 3 cycles at cnt_o=5 -> cnt_o holds 5 with end_cnt_o low, then resumes to 6.
- Period stretches to 13 cycles.
REQ-028 flag_cnt_i dropped at cnt_o=9 -> end_cnt_o low and cnt_o held at 9 during the drop.
- On re-enable, end_cnt_o is high for one cycle, then cnt_o=0 and tx_valid_o=1.
REQ-029 rst asserted for 1 edge when cnt_o=9 and flag_cnt_i=1 -> next cycle cnt_o=0, tx_valid_o=0, tx_cnt_o=0.
REQ-030 TX_WIDTH=2 with 5 wraps -> tx_cnt_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/counter_tx.sv
// counter_tx: modulo-(CNT_MAX+1) enabled counter that emits a one-cycle
// transmit strobe after each terminal count and keeps a running count of
// the strobes it has issued.
//
// Parameters
//   CNT_WIDTH  width of the count register / cnt_o (1..32)
//   CNT_MAX    terminal count value (1..2**CNT_WIDTH-1)
//   TX_WIDTH   width of the transmit counter tx_cnt_o (1..32)
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   synchronous, active-high reset
//   flag_cnt_i  in   count enable
//   cnt_o       out  current count, registered
//   end_cnt_o   out  terminal-count strobe, combinational
//   tx_valid_o  out  one-cycle transmit strobe, registered
//   tx_cnt_o    out  number of strobes issued, modulo 2**TX_WIDTH
//
// Handshake: tx_valid_o is a valid-only strobe with no ready back-pressure.
// It is high for exactly one cycle per wrap, and the consumer must take it
// in that cycle. tx_cnt_o already holds the updated count in the cycle
// where tx_valid_o is high.
module counter_tx #(
  parameter int CNT_WIDTH = 4,
  parameter int CNT_MAX   = 9,
  parameter int TX_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flag_cnt_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 end_cnt_o,
  output logic                 tx_valid_o,
  output logic [TX_WIDTH-1:0]  tx_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] MAX_VAL = CNT_WIDTH'(CNT_MAX);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 tx_valid_q;
  logic [TX_WIDTH-1:0]  tx_cnt_q;

  // Terminal count only counts while enabled. rst does not enter this term;
  // a reset edge clears cnt_q, which then removes the strobe on its own.
  assign end_cnt_o = flag_cnt_i & (cnt_q == MAX_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_cnt_q   <= '0;
    end else begin
      tx_valid_q <= end_cnt_o;
      if (end_cnt_o) begin
        cnt_q    <= '0;
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end else if (flag_cnt_i) begin
        // A count above the terminal value cannot arise through counting.
        // It is handled anyway, so that a corrupted register comes back to
        // zero and does not run through the unused codes.
        if (cnt_q > MAX_VAL) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign cnt_o      = cnt_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_cnt_o   = tx_cnt_q;

endmodule

// File: tb/tb_counter_tx.sv
// Directed bench for counter_tx. A default instance (CNT_MAX=9, TX_WIDTH=8)
// and a TX_WIDTH=2 instance share the same clock, reset and enable.
module tb_counter_tx;

  logic       clk;
  logic       rst;
  logic       flag_cnt_i;
  logic [3:0] cnt_o;
  logic       end_cnt_o;
  logic       tx_valid_o;
  logic [7:0] tx_cnt_o;

  logic [3:0] cnt2_o;
  logic       end2_o;
  logic       tx_valid2_o;
  logic [1:0] tx_cnt2_o;

  int vectors = 0;
  int errors  = 0;

  logic [1:0] exp_q[$];

  counter_tx dut (
    .clk        (clk),
    .rst        (rst),
    .flag_cnt_i (flag_cnt_i),
    .cnt_o      (cnt_o),
    .end_cnt_o  (end_cnt_o),
    .tx_valid_o (tx_valid_o),
    .tx_cnt_o   (tx_cnt_o)
  );

  counter_tx #(.CNT_WIDTH(4), .CNT_MAX(9), .TX_WIDTH(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .flag_cnt_i (flag_cnt_i),
    .cnt_o      (cnt2_o),
    .end_cnt_o  (end2_o),
    .tx_valid_o (tx_valid2_o),
    .tx_cnt_o   (tx_cnt2_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver / check tasks ----------------
  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count with the enable high from 'from' up to 'to' (to <= 9), checking
  // every cycle. tx_cnt must stay at tx_exp throughout.
  task automatic count_up(input int from, input int to, input int tx_exp);
    for (int v = from + 1; v <= to; v++) begin
      step();
      check("cnt", 32'(cnt_o), 32'(v));
      check("end_cnt", 32'(end_cnt_o), (v == 9) ? 32'd1 : 32'd0);
      check("tx_valid_low", 32'(tx_valid_o), 32'd0);
      check("tx_cnt_hold", 32'(tx_cnt_o), 32'(tx_exp));
    end
  endtask

  // One edge taken with end_cnt high. Expect wrap to 0, the strobe, and the
  // new transmit counts in both instances.
  task automatic wrap(input int tx_exp, input int tx2_exp);
    check("end_before_wrap", 32'(end_cnt_o), 32'd1);
    step();
    check("wrap_cnt", 32'(cnt_o), 32'd0);
    check("wrap_end", 32'(end_cnt_o), 32'd0);
    check("wrap_tx_valid", 32'(tx_valid_o), 32'd1);
    check("wrap_tx_cnt", 32'(tx_cnt_o), 32'(tx_exp));
    check("wrap_tx_cnt_w2", 32'(tx_cnt2_o), 32'(tx2_exp));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst        = 1'b1;
    flag_cnt_i = 1'b0;

    // Reset for two edges.
    step();
    step();
    check("rst_cnt", 32'(cnt_o), 32'd0);
    check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check("rst_tx_cnt", 32'(tx_cnt_o), 32'd0);
    check("rst_tx_cnt_w2", 32'(tx_cnt2_o), 32'd0);
    check("rst_end", 32'(end_cnt_o), 32'd0);
    // Enable high during reset with cnt=0 leaves end_cnt low.
    flag_cnt_i = 1'b1;
    #1;
    check("rst_end_flag", 32'(end_cnt_o), 32'd0);
    step();
    check("rst_hold_cnt", 32'(cnt_o), 32'd0);

    // First period: 0..9 and a wrap, tx_cnt=1.
    rst = 1'b0;
    count_up(0, 9, 0);
    wrap(1, 1);

    // Second period back to back: end_cnt rises again 10 cycles later.
    count_up(0, 9, 1);
    wrap(2, 2);

    // Enable dropped for 3 cycles at cnt=5.
    count_up(0, 5, 2);
    flag_cnt_i = 1'b0;
    #1;
    check("drop5_end", 32'(end_cnt_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("drop5_cnt", 32'(cnt_o), 32'd5);
      check("drop5_end_hold", 32'(end_cnt_o), 32'd0);
      check("drop5_tx_valid", 32'(tx_valid_o), 32'd0);
    end
    flag_cnt_i = 1'b1;
    count_up(5, 9, 2);
    wrap(3, 3);

    // Enable dropped while cnt=9: end_cnt is suppressed and the count holds.
    count_up(0, 9, 3);
    flag_cnt_i = 1'b0;
    #1;
    check("drop9_end", 32'(end_cnt_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("drop9_cnt", 32'(cnt_o), 32'd9);
      check("drop9_end_hold", 32'(end_cnt_o), 32'd0);
      check("drop9_tx_valid", 32'(tx_valid_o), 32'd0);
      check("drop9_tx_cnt", 32'(tx_cnt_o), 32'd3);
    end
    flag_cnt_i = 1'b1;
    #1;
    wrap(4, 0);

    // Reset on an edge where end_cnt is high: reset wins and no strobe follows.
    count_up(0, 9, 4);
    check("pre_rst_end", 32'(end_cnt_o), 32'd1);
    rst = 1'b1;
    step();
    check("rst9_cnt", 32'(cnt_o), 32'd0);
    check("rst9_tx_valid", 32'(tx_valid_o), 32'd0);
    check("rst9_tx_cnt", 32'(tx_cnt_o), 32'd0);
    check("rst9_tx_cnt_w2", 32'(tx_cnt2_o), 32'd0);
    check("rst9_end", 32'(end_cnt_o), 32'd0);
    rst = 1'b0;

    // Five wraps: the 2-bit transmit counter goes 1,2,3,0,1.
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    for (int w = 1; w <= 5; w++) begin
      count_up(0, 9, w - 1);
      check("w2_end", 32'(end2_o), 32'd1);
      wrap(w, int'(exp_q.pop_front()));
      check("w2_tx_valid", 32'(tx_valid2_o), 32'd1);
      check("w2_cnt", 32'(cnt2_o), 32'd0);
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
